fetch_issue_queue: RTL and testbench

Parametrised, power-of-two-depth instruction buffer between fetch and decode/dispatch in the out-of-order core. It accepts one instruction per cycle from fetch through a valid/ready handshake. It presents the two oldest entries first-word-fall-through so dispatch can consume 0, 1 or 2 instructions per cycle. A single-cycle flush empties it on branch mispredict; occupancy count and an almost-full flag support fetch throttling.

---
 rtl/fetch_issue_queue.sv | 111 +++++++++++
 tb/tb_fetch_issue_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_queue.sv
// -----------------------------------------------------------------------------
// fetch_issue_queue
//
// Instruction buffer between fetch and decode/dispatch. Fetch pushes one entry
// per cycle through a valid/ready handshake. The two oldest entries are shown
// first-word-fall-through, so dispatch can take 0, 1 or 2 of them each cycle.
// flush (branch mispredict / redirect) empties the queue in one cycle.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (same effect as flush)
//   flush             discard every entry; wins over same-cycle enq/deq
//   enq_valid/ready   fetch handshake; enq_ready = !full (registered state only)
//   enq_data          payload to write
//   deq_valid0/data0  oldest entry (valid when count >= 1)
//   deq_valid1/data1  second-oldest entry (valid when count >= 2)
//   deq_count         entries consumed this cycle; clamped to 2 and to count
//   count, empty, full, almost_full   occupancy status, combinational
// -----------------------------------------------------------------------------
module fetch_issue_queue #(
    parameter int WIDTH        = 66,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     enq_ready,
    output logic                     deq_valid0,
    output logic [WIDTH-1:0]         deq_data0,
    output logic                     deq_valid1,
    output logic [WIDTH-1:0]         deq_data1,
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] count_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [IDX_W-1:0] head_next_idx_s;
    logic [1:0]       req_s;
    logic [1:0]       eff_s;
    logic             enq_fire_s;

    // Occupancy and status: the extra pointer bit makes tail - head exact
    // for both empty (0) and full (DEPTH).
    always_comb begin
        count_s     = tail_r - head_r;
        count       = count_s;
        empty       = (count_s == {PTR_W{1'b0}});
        full        = (count_s == PTR_W'(DEPTH));
        almost_full = (count_s >= PTR_W'(AFULL_THRESH));
        enq_ready   = !full;
        deq_valid0  = !empty;
        deq_valid1  = (count_s >= PTR_W'(2));
        enq_fire_s  = enq_valid && !full;
    end

    // Read side: index arithmetic is done at IDX_W bits so head+1 wraps
    // from DEPTH-1 back to 0 on its own.
    always_comb begin
        head_idx_s      = head_r[IDX_W-1:0];
        head_next_idx_s = head_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
        deq_data0       = mem_r[head_idx_s];
        deq_data1       = mem_r[head_next_idx_s];
    end

    // Effective dequeue amount: 3 behaves as 2, and never more than present.
    always_comb begin
        case (deq_count)
            2'd0:    req_s = 2'd0;
            2'd1:    req_s = 2'd1;
            default: req_s = 2'd2;
        endcase
        if (count_s >= {{(PTR_W-2){1'b0}}, req_s}) begin
            eff_s = req_s;
        end else begin
            eff_s = count_s[1:0];
        end
    end

    // Pointer pair; rst and flush both return the queue to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
        end else begin
            head_r <= head_r + {{(PTR_W-2){1'b0}}, eff_s};
            if (enq_fire_s) begin
                tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents are intentionally not cleared by rst.
    always_ff @(posedge clk) begin
        if (enq_fire_s && !rst && !flush) begin
            mem_r[tail_r[IDX_W-1:0]] <= enq_data;
        end
    end

endmodule

// File: tb/tb_fetch_issue_queue.sv
module tb_fetch_issue_queue;

    localparam int W = 66;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         enq_valid;
    logic [W-1:0] enq_data;
    logic         enq_ready;
    logic         deq_valid0;
    logic [W-1:0] deq_data0;
    logic         deq_valid1;
    logic [W-1:0] deq_data1;
    logic [1:0]   deq_count;
    logic [3:0]   count;
    logic         empty;
    logic         full;
    logic         almost_full;

    int checks     = 0;
    int failures   = 0;
    int proto_hits = 0;

    // {count, empty, full, enq_ready, deq_valid0, deq_valid1, almost_full}
    logic [9:0] status;
    assign status = {count, empty, full, enq_ready, deq_valid0, deq_valid1, almost_full};
    localparam logic [9:0] RESET_STATUS = {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    fetch_issue_queue #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(D - 2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .deq_valid0(deq_valid0), .deq_data0(deq_data0),
        .deq_valid1(deq_valid1), .deq_data1(deq_data1),
        .deq_count(deq_count), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; enq_valid = 1'b0; deq_count = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enq_data = '0; idle_inputs();
        step(); step();
        rst = 1'b0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL reset_status got=%b exp=%b", status, RESET_STATUS);
        end
    endtask

    task automatic test_enqueue_abc();
        logic [W-1:0] v [3];
        v[0] = 66'h2_0000_0000_0000_000A;
        v[1] = 66'h1_0000_0000_0000_000B;
        v[2] = 66'h3_FFFF_0000_0000_000C;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_data = v[i];
            step();
            checks++;
            if (count !== 4'(i + 1)) begin
                failures++; $display("FAIL abc_count%0d got=%0d exp=%0d", i, count, i + 1);
            end
        end
        enq_valid = 1'b0;
        checks++;
        if (deq_data0 !== v[0]) begin
            failures++; $display("FAIL abc_data0 got=%h exp=%h", deq_data0, v[0]);
        end
        checks++;
        if (deq_data1 !== v[1]) begin
            failures++; $display("FAIL abc_data1 got=%h exp=%h", deq_data1, v[1]);
        end
        checks++;
        if (status !== {4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL abc_status got=%b exp=%b", status, {4'd3, 6'b001110});
        end
        flush = 1'b1; step(); flush = 1'b0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL abc_flush got=%b exp=%b", status, RESET_STATUS);
        end
    endtask

    task automatic test_fill_and_stall();
        logic [9:0] exp_s;
        for (int i = 0; i < D; i++) begin
            enq_valid = 1'b1; enq_data = 66'(i);
            step();
            exp_s = {4'(i + 1), 1'b0, (i + 1 == D), (i + 1 != D), 1'b1, (i + 1 >= 2), (i + 1 >= 6)};
            checks++;
            if (status !== exp_s) begin
                failures++; $display("FAIL fill_status%0d got=%b exp=%b", i, status, exp_s);
            end
        end
        // full, enq held with a single dequeue: dequeue happens, enqueue stalls
        enq_valid = 1'b1; enq_data = 66'd8; deq_count = 2'd1;
        step();
        checks++;
        if (status !== {4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1} || deq_data0 !== 66'd1) begin
            failures++; $display("FAIL stall_deq got=%b/%0d exp=%b/1", status, deq_data0, {4'd7, 6'b001111});
        end
        deq_count = 2'd0;
        step();
        checks++;
        if (status !== {4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            failures++; $display("FAIL stall_accept got=%b exp=%b", status, {4'd8, 6'b010111});
        end
        enq_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (deq_data0 !== 66'(1 + 2 * j) || deq_data1 !== 66'(2 + 2 * j)) begin
                failures++; $display("FAIL drain_pair%0d got=%0d,%0d exp=%0d,%0d", j, deq_data0, deq_data1, 1 + 2 * j, 2 + 2 * j);
            end
            deq_count = 2'd2;
            step();
        end
        deq_count = 2'd0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL drain_empty got=%b exp=%b", status, RESET_STATUS);
        end
    endtask

    task automatic test_steady_state();
        logic [W-1:0] model [$];
        int eff;
        for (int c = 0; c < 40; c++) begin
            enq_valid = 1'b1; enq_data = 66'(200 + c);
            deq_count = deq_valid1 ? 2'd2 : 2'd0;
            eff = (int'(deq_count) < model.size()) ? int'(deq_count) : model.size();
            if (model.size() < D) model.push_back(enq_data);
            for (int k = 0; k < eff; k++) void'(model.pop_front());
            step();
            checks++;
            if (count !== 4'(model.size())) begin
                failures++; $display("FAIL steady_count c=%0d got=%0d exp=%0d", c, count, model.size());
            end
            if (model.size() >= 1) begin
                checks++;
                if (deq_data0 !== model[0]) begin
                    failures++; $display("FAIL steady_data0 c=%0d got=%0d exp=%0d", c, deq_data0, model[0]);
                end
            end
            if (model.size() >= 2) begin
                checks++;
                if (deq_data1 !== model[1]) begin
                    failures++; $display("FAIL steady_data1 c=%0d got=%0d exp=%0d", c, deq_data1, model[1]);
                end
            end
        end
        enq_valid = 1'b0;
        for (int k = 0; k < 10 && model.size() > 0; k++) begin
            deq_count = (model.size() >= 2) ? 2'd2 : 2'd1;
            void'(model.pop_front());
            if (deq_count == 2'd2) void'(model.pop_front());
            step();
        end
        deq_count = 2'd0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL steady_drain got=%b exp=%b", status, RESET_STATUS);
        end
    endtask

    task automatic test_over_dequeue();
        int exp_cnt;
        enq_valid = 1'b1; enq_data = 66'h3A; step(); enq_valid = 1'b0;
        exp_cnt = 1;
        deq_count = 2'd2;
        if (int'(deq_count) > exp_cnt) proto_hits++;
        step();
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL overdeq_one got=%b exp=%b", status, RESET_STATUS);
        end
        exp_cnt = 0;
        if (int'(deq_count) > exp_cnt) proto_hits++;
        step();
        deq_count = 2'd0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL overdeq_empty got=%b exp=%b", status, RESET_STATUS);
        end
        enq_valid = 1'b1; enq_data = 66'h3B; step(); enq_valid = 1'b0;
        checks++;
        if (deq_data0 !== 66'h3B || count !== 4'd1) begin
            failures++; $display("FAIL overdeq_next got=%h/%0d exp=3b/1", deq_data0, count);
        end
        deq_count = 2'd1; step(); deq_count = 2'd0;
        $display("protocol errors flagged by bench: %0d", proto_hits);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1; enq_data = 66'(16'h50 + i); step();
        end
        checks++;
        if (count !== 4'd5) begin
            failures++; $display("FAIL flush_pre_count got=%0d exp=5", count);
        end
        flush = 1'b1; enq_valid = 1'b1; enq_data = 66'hEE; deq_count = 2'd2;
        step();
        flush = 1'b0; deq_count = 2'd0; enq_data = 66'h77;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL flush_status got=%b exp=%b", status, RESET_STATUS);
        end
        step();
        enq_valid = 1'b0;
        checks++;
        if (deq_data0 !== 66'h77 || count !== 4'd1) begin
            failures++; $display("FAIL flush_next got=%h/%0d exp=77/1", deq_data0, count);
        end
        deq_count = 2'd1; step(); deq_count = 2'd0;
    endtask

    task automatic test_rst_while_full();
        for (int i = 0; i < D; i++) begin
            enq_valid = 1'b1; enq_data = 66'(16'h90 + i); step();
        end
        checks++;
        if (full !== 1'b1 || enq_ready !== 1'b0) begin
            failures++; $display("FAIL rstfull_pre got=full%b/rdy%b exp=1/0", full, enq_ready);
        end
        rst = 1'b1; step(); rst = 1'b0; enq_valid = 1'b0;
        checks++;
        if (status !== RESET_STATUS) begin
            failures++; $display("FAIL rstfull_status got=%b exp=%b", status, RESET_STATUS);
        end
        enq_valid = 1'b1; enq_data = 66'h2_1234_5678_9ABC_DEF0; step(); enq_valid = 1'b0;
        checks++;
        if (deq_data0 !== 66'h2_1234_5678_9ABC_DEF0 || count !== 4'd1) begin
            failures++; $display("FAIL rstfull_next got=%h/%0d exp=212345678_9abcdef0/1", deq_data0, count);
        end
    endtask

    initial begin
        test_reset();
        test_enqueue_abc();
        test_fill_and_stall();
        test_steady_state();
        test_over_dequeue();
        test_flush();
        test_rst_while_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
